// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shared constants, FSM states and operand record for shift_arbiter.
package shift_arbiter_pkg;
  localparam int WIDTH = 16;
  localparam int SHAMT_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, RESP, SHIFT2} state_e;
  typedef logic id_t;
  typedef struct packed {
    logic                dir;
    logic [SHAMT_W-1:0]  shamt;
    logic [WIDTH-1:0]    data;
    id_t                 id;
    logic                rot;
  } oper_t;
endpackage

// File: rtl/shift_arbiter_shifter.sv
// shift_arbiter_shifter: 16-bit logical barrel shifter, zero fill, dir 1 = left.
module shift_arbiter_shifter
  import shift_arbiter_pkg::*;
(
  input  logic               dir_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic [WIDTH-1:0]   result_o
);
  assign result_o = dir_i ? data_i << shamt_i : data_i >> shamt_i;
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel shifter between two requesters.
// Optional rotate support (extra SHIFT2 pass) under SHIFT_ARBITER_ROTATE_EN.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic               req0_dir_i,
  input  logic [SHAMT_W-1:0] req0_shamt_i,
  input  logic [WIDTH-1:0]   req0_data_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic               req1_dir_i,
  input  logic [SHAMT_W-1:0] req1_shamt_i,
  input  logic [WIDTH-1:0]   req1_data_i,
`ifdef SHIFT_ARBITER_ROTATE_EN
  input  logic               req0_rot_i,
  input  logic               req1_rot_i,
`endif
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_id_o,
  output logic [WIDTH-1:0]   rsp_result_o,
  output logic               busy_o
);
  state_e state_q, state_d;
  id_t rr_q, rr_d, rsp_id_q, rsp_id_d;
  oper_t op_q, op_d, in0, in1;
  logic rsp_valid_q, rsp_valid_d, idle, sh_dir;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d, sh_out;
  logic [SHAMT_W-1:0] sh_amt;
  assign idle = (state_q == IDLE) & ~rst_i;
  assign req0_ready_o = idle & req0_valid_i & (~req1_valid_i | (rr_q == 1'b0));
  assign req1_ready_o = idle & req1_valid_i & (~req0_valid_i | (rr_q == 1'b1));
`ifdef SHIFT_ARBITER_ROTATE_EN
  logic [WIDTH-1:0] part_q, part_d;
  assign in0 = '{dir: req0_dir_i, shamt: req0_shamt_i, data: req0_data_i, id: 1'b0, rot: req0_rot_i};
  assign in1 = '{dir: req1_dir_i, shamt: req1_shamt_i, data: req1_data_i, id: 1'b1, rot: req1_rot_i};
  // Second rotate pass: opposite direction by WIDTH - s (mod 2^SHAMT_W).
  assign sh_dir = (state_q == SHIFT2) ? ~op_q.dir : op_q.dir;
  assign sh_amt = (state_q == SHIFT2) ? -op_q.shamt : op_q.shamt;
`else
  logic unused_rot;
  assign in0 = '{dir: req0_dir_i, shamt: req0_shamt_i, data: req0_data_i, id: 1'b0, rot: 1'b0};
  assign in1 = '{dir: req1_dir_i, shamt: req1_shamt_i, data: req1_data_i, id: 1'b1, rot: 1'b0};
  assign sh_dir = op_q.dir;
  assign sh_amt = op_q.shamt;
  assign unused_rot = op_q.rot;
`endif
  shift_arbiter_shifter u_shifter (
    .dir_i   (sh_dir),
    .shamt_i (sh_amt),
    .data_i  (op_q.data),
    .result_o(sh_out)
  );
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    op_d = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_result_d = rsp_result_q;
`ifdef SHIFT_ARBITER_ROTATE_EN
    part_d = part_q;
`endif
    case (state_q)
      IDLE: if (req0_ready_o | req1_ready_o) begin
        op_d = req1_ready_o ? in1 : in0;
        state_d = SHIFT;
      end
      SHIFT: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
        if (op_q.rot && op_q.shamt != '0) begin
          part_d = sh_out;
          state_d = SHIFT2;
        end else
`endif
        begin
          rsp_result_d = sh_out;
          rsp_id_d = op_q.id;
          rsp_valid_d = 1'b1;
          state_d = RESP;
        end
      end
`ifdef SHIFT_ARBITER_ROTATE_EN
      SHIFT2: begin
        rsp_result_d = part_q | sh_out;
        rsp_id_d = op_q.id;
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end
`endif
      RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        rr_d = ~rsp_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      op_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_result_q <= '0;
`ifdef SHIFT_ARBITER_ROTATE_EN
      part_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      op_q <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
`ifdef SHIFT_ARBITER_ROTATE_EN
      part_q <= part_d;
`endif
    end
  end
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign busy_o = state_q != IDLE;
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 16-bit barrel shifter between two requesters (port 0, port 1).
- Round-robin arbitration; valid/ready handshake on each request port and on the response port.
- Operands are captured, the shifter is driven from registers, and the result is registered with the winning requester's ID.
- Sits between the ALU-side shift requesters and the shifter datapath instance.

Parameters:
- WIDTH, 16, data width; fixed to the shifter width; other values unsupported.
- SHAMT_W, 4, shift-amount width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 request accepted this cycle.
- req0_dir_i  in  1  1 = left, 0 = right.
- req0_shamt_i  in  SHAMT_W  shift amount.
- req0_data_i  in  WIDTH  source operand.
- req1_valid_i, req1_ready_o, req1_dir_i, req1_shamt_i, req1_data_i: same as port 0, for port 1.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer accepts result.
- rsp_id_o  out  1  requester ID of the result.
- rsp_result_o  out  WIDTH  shifted result.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, captured operands=0.
  - rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, busy_o=0.
  - Both ready outputs are 0 while rst_i is high.
- Shift semantics: logical shift with zero fill; shamt 0 passes data unchanged; shamt 15 leaves one surviving bit.
- Grant (combinational, evaluated in IDLE only):
  - grant0 = req0_valid_i & (~req1_valid_i | rr_ptr==0).
  - grant1 = req1_valid_i & (~req0_valid_i | rr_ptr==1).
  - reqN_ready_o = (state==IDLE) & grantN. At most one ready is high per cycle.
  - ready may depend on valid; valid must not depend on ready.
- FSM:
  - IDLE: on a handshake, capture dir, shamt, data and ID, then go to SHIFT. No valid: stay in IDLE.
  - SHIFT: drive the shifter from the captured registers. At the clock edge, register the shifter output into rsp_result_o, set rsp_id_o = ID, set rsp_valid_o=1, go to RESP.
  - RESP: hold rsp_valid_o and the data stable until rsp_ready_i=1. On that edge: clear rsp_valid_o, set rr_ptr = ~ID, go to IDLE.
- Latency and throughput:
  - Accept at edge N; rsp_valid_o is high after edge N+1.
  - With rsp_ready_i tied high, one operation every 3 cycles.
- rr_ptr changes only on response handshake, so a lone requester is served back-to-back.
- Boundary conditions:
  - Both requesters valid in IDLE: rr_ptr decides the winner; the loser keeps valid and its operands stable.
  - Requests arriving in SHIFT or RESP see ready=0 and must wait.
  - rsp_ready_i high before rsp_valid_o has no effect.
  - Reset mid-operation: the transaction is discarded immediately (asynchronously); no partial response is produced.

Optional Feature:
- Macro: SHIFT_ARBITER_ROTATE_EN.
- Defined:
  - Adds input ports req0_rot_i and req1_rot_i, captured with the other operands.
  - A rotate with shamt s != 0 takes an extra state, SHIFT2:
    - SHIFT computes the primary shift in dir and stores it in a partial register.
    - SHIFT2 reuses the same shifter with the opposite direction and shamt = WIDTH - s, ORs that with the partial, then enters RESP.
  - Rotate with s=0 skips SHIFT2.
  - Rotate latency is one cycle longer than a plain shift.
- Undefined: the rot ports and SHIFT2 do not exist; behaviour is exactly as above.

Decomposition:
- Package shift_arbiter_pkg:
  - WIDTH and SHAMT_W constants.
  - State enum typedef (IDLE, SHIFT, RESP, SHIFT2).
  - Requester-ID typedef (1 bit).
  - Operand struct typedef: dir, shamt, data, id, rot.
- Sub-module: one instance of the existing 16-bit barrel shifter.
- Arbitration and FSM are inline; no further sub-modules.

Test Plan:
- Single request: req0 valid, dir=1, shamt=4, data=16'h00F3 -> accepted next edge; rsp_valid_o high 2 cycles after valid; rsp_result_o=16'h0F30, rsp_id_o=0.
- Simultaneous requests after reset (rr_ptr=0): req0 16'h8000 right 15, req1 16'h0001 left 15 -> first response id 0 / 16'h0001, second response id 1 / 16'h8000.
- Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rsp_result_o and rsp_id_o stable; both readys 0; on release -> one handshake, then return to IDLE.
- Shamt 0, data 16'hA5A5, either dir -> rsp_result_o=16'hA5A5.
- Assert rst_i in SHIFT -> rsp_valid_o=0 and busy_o=0 asynchronously; after release, a new req1 request is served first with correct result.
- With SHIFT_ARBITER_ROTATE_EN: rot=1, dir=1, shamt=4, data=16'h1234 -> rsp_result_o=16'h2341 with one extra cycle of latency.
